// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: a single-outstanding fetch FSM feeding a DEPTH-entry
// {instr, pc} FIFO whose head drives the control unit.
// Optional build macro FETCH_STATS_EN adds the saturating stat_fetched and
// stat_flushes counters.
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] ir,
  output logic [63:0] ir_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic        redirect,
  input  logic [63:0] redirect_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] stat_fetched,
  output logic [15:0] stat_flushes
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    SQUASH = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [63:0]   fetch_pc;
  logic [63:0]   req_addr;
  logic [31:0]   q_instr [DEPTH];
  logic [63:0]   q_pc    [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop;

  assign ir_valid  = (count != '0);
  assign ir        = ir_valid ? q_instr[rd_ptr] : 32'h0;
  assign ir_pc     = ir_valid ? q_pc[rd_ptr] : 64'h0;
  assign imem_addr = req_addr;

  // Fetch FSM state register
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Fetch FSM next state, request strobe and queue push/pop decisions
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    push      = 1'b0;
    pop       = ir_valid && ir_ready && !redirect;
    case (state)
      IDLE: begin
        if (!redirect && (count < FULL_CNT)) state_nxt = REQ;
      end
      REQ: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          state_nxt = IDLE;
          // A redirect on the ack cycle turns the returning word into wrong-path data.
          push      = !redirect;
        end else if (redirect) begin
          state_nxt = SQUASH;
        end
      end
      SQUASH: begin
        // The stale request must still complete on the bus; its data is dropped.
        imem_req = 1'b1;
        if (imem_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Fetch PC tracking and latching of the address for the outstanding request
  always_ff @(posedge clock) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      if (redirect)  fetch_pc <= redirect_pc;
      else if (push) fetch_pc <= fetch_pc + 64'd4;
      if (state == IDLE && state_nxt == REQ) req_addr <= fetch_pc;
    end
  end

  // Queue pointers and occupancy; a redirect flushes everything
  always_ff @(posedge clock) begin
    if (!reset || redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Queue storage; contents are only meaningful below count, so no reset
  always_ff @(posedge clock) begin
    if (push) begin
      q_instr[wr_ptr] <= imem_data;
      q_pc[wr_ptr]    <= req_addr;
    end
  end

`ifdef FETCH_STATS_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  // Saturating fetch and flush event counters
  always_ff @(posedge clock) begin
    if (!reset) begin
      stat_fetched <= 32'd0;
      stat_flushes <= 16'd0;
    end else begin
      if (push)     stat_fetched <= sat_inc32(stat_fetched);
      if (redirect) stat_flushes <= sat_inc16(stat_flushes);
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed vector tables, hand-written corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_instr_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data;
  logic [31:0] ir;
  logic [63:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched;
  logic [15:0] stat_flushes;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock       (clock),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .ir          (ir),
    .ir_pc       (ir_pc),
    .ir_valid    (ir_valid),
    .ir_ready    (ir_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched(stat_fetched),
    .stat_flushes(stat_flushes)
`endif
  );

  // Instruction memory contents: word 0 is ADDI X4,XZR,100.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h0) return 32'h910193E4;
    return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h0BADF00D;
  endfunction

  always_comb imem_data = mem_word(imem_addr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input bit ereq, input logic [63:0] eaddr,
                           input bit evld, input logic [63:0] epc);
    chk({tag, ".imem_req"}, {63'h0, imem_req}, {63'h0, ereq});
    if (ereq) chk({tag, ".imem_addr"}, imem_addr, eaddr);
    chk({tag, ".ir_valid"}, {63'h0, ir_valid}, {63'h0, evld});
    chk({tag, ".ir_pc"}, ir_pc, evld ? epc : 64'h0);
    chk({tag, ".ir"}, {32'h0, ir}, {32'h0, evld ? mem_word(epc) : 32'h0});
  endtask

  task automatic step(input bit r, input bit a, input bit rd, input bit rr, input logic [63:0] rp);
    reset       = r;
    imem_ack    = a;
    ir_ready    = rd;
    redirect    = rr;
    redirect_pc = rp;
    @(posedge clock);
    @(negedge clock);
  endtask

  typedef struct {
    bit          rst;
    bit          ack;
    bit          rdy;
    bit          rdr;
    logic [63:0] rpc;
    bit          chk;
    bit          ereq;
    logic [63:0] eaddr;
    bit          evld;
    logic [63:0] epc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit rst, input bit ack, input bit rdy, input bit rdr,
                     input logic [63:0] rpc, input bit c, input bit ereq,
                     input logic [63:0] eaddr, input bit evld, input logic [63:0] epc);
    tbl.push_back('{rst, ack, rdy, rdr, rpc, c, ereq, eaddr, evld, epc});
  endtask

  // Reference model: a queue of fetched entries plus the outstanding request.
  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
  } ent_t;

  ent_t        mq[$];
  bit          m_out;
  bit          m_stale;
  logic [63:0] m_addr;
  logic [63:0] m_fpc;
  int          m_fetched;
  int          m_flushes;

  task automatic model_step(input bit r, input bit a, input bit rd, input bit rr, input logic [63:0] rp);
    int n;
    if (!r) begin
      mq.delete();
      m_out = 0; m_stale = 0; m_fpc = RESET_PC; m_addr = RESET_PC;
      m_fetched = 0; m_flushes = 0;
      return;
    end
    n = mq.size();
    if (rr) begin
      mq.delete();
      m_fpc = rp;
      m_flushes++;
      if (m_out && a) begin m_out = 0; m_stale = 0; end
      else if (m_out) m_stale = 1;
    end else begin
      if (n > 0 && rd) void'(mq.pop_front());
      if (m_out) begin
        if (a) begin
          if (!m_stale) begin
            mq.push_back('{mem_word(m_addr), m_addr});
            m_fpc = m_fpc + 64'd4;
            m_fetched++;
          end
          m_out = 0; m_stale = 0;
        end
      end else if (n < DEPTH) begin
        m_out  = 1;
        m_addr = m_fpc;
      end
    end
  endtask

  initial begin
    // Fill-to-full then single pop, with ack answering every request at once.
    add(0,0,0,0,0,       0,0,0,0,0);
    add(0,0,0,0,0,       1,0,0,0,0);
    add(1,0,0,0,0,       1,0,0,0,0);
    add(1,1,0,0,0,       1,1,0,0,0);
    add(1,0,0,0,0,       1,0,0,1,0);
    add(1,1,0,0,0,       1,1,4,1,0);
    add(1,0,0,0,0,       1,0,0,1,0);
    add(1,1,0,0,0,       1,1,8,1,0);
    add(1,0,0,0,0,       1,0,0,1,0);
    add(1,1,0,0,0,       1,1,12,1,0);
    add(1,0,0,0,0,       1,0,0,1,0);
    add(1,0,1,0,0,       1,0,0,1,0);
    add(1,0,0,0,0,       1,0,0,1,4);
    add(1,1,0,0,0,       1,1,16,1,4);
    add(1,0,0,0,0,       1,0,0,1,4);
    add(1,0,0,0,0,       1,0,0,1,4);
    // Redirect to 0x40 while the request for 0x8 waits; ack arrives 2 cycles later.
    add(0,0,0,0,0,       0,0,0,0,0);
    add(0,0,0,0,0,       1,0,0,0,0);
    add(1,0,1,0,0,       1,0,0,0,0);
    add(1,1,1,0,0,       1,1,0,0,0);
    add(1,0,1,0,0,       1,0,0,1,0);
    add(1,1,1,0,0,       1,1,4,0,0);
    add(1,0,1,0,0,       1,0,0,1,4);
    add(1,0,1,1,'h40,    1,1,8,0,0);
    add(1,0,1,0,0,       1,1,8,0,0);
    add(1,1,1,0,0,       1,1,8,0,0);
    add(1,0,1,0,0,       1,0,0,0,0);
    add(1,1,0,0,0,       1,1,'h40,0,0);
    add(1,0,0,0,0,       1,0,0,1,'h40);
    add(1,0,0,0,0,       1,1,'h44,1,'h40);

    @(negedge clock);
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].chk) check_out($sformatf("vec%0d", i), tbl[i].ereq, tbl[i].eaddr, tbl[i].evld, tbl[i].epc);
      step(tbl[i].rst, tbl[i].ack, tbl[i].rdy, tbl[i].rdr, tbl[i].rpc);
    end

    // Redirect, ack and ready in one cycle: flush wins and the ack data is lost.
    step(0,0,0,0,0); step(0,0,0,0,0);
    check_out("flush.c0", 0,0,0,0);          step(1,0,0,0,0);
    check_out("flush.c1", 1,0,0,0);          step(1,1,0,0,0);
    check_out("flush.c2", 0,0,1,0);          step(1,0,0,0,0);
    check_out("flush.c3", 1,4,1,0);          step(1,1,1,1,'h100);
    check_out("flush.c4", 0,0,0,0);          step(1,0,0,0,0);
    check_out("flush.c5", 1,'h100,0,0);      step(1,1,0,0,0);
    check_out("flush.c6", 0,0,1,'h100);      step(1,0,1,0,0);
    check_out("flush.c7", 1,'h104,0,0);      step(1,0,0,0,0);

    // Reset while a request is outstanding: dropped, fetch restarts at RESET_PC.
    step(0,0,0,0,0); step(0,0,0,0,0);
    check_out("rst.c0", 0,0,0,0);            step(1,0,0,1,'h200);
    check_out("rst.c1", 0,0,0,0);            step(1,0,0,0,0);
    check_out("rst.c2", 1,'h200,0,0);        step(1,1,0,0,0);
    check_out("rst.c3", 0,0,1,'h200);        step(1,0,0,0,0);
    check_out("rst.c4", 1,'h204,1,'h200);    step(0,0,0,0,0);
    check_out("rst.c5", 0,0,0,0);            step(1,0,0,0,0);
    check_out("rst.c6", 1,RESET_PC,0,0);     step(1,1,0,0,0);
    check_out("rst.c7", 0,0,1,RESET_PC);
    chk("rst.ir_word0", {32'h0, ir}, 64'h910193E4);

    // Randomized traffic against the reference model.
    model_step(0,0,0,0,0); step(0,0,0,0,0);
    model_step(0,0,0,0,0); step(0,0,0,0,0);
    for (int i = 0; i < 3000; i++) begin
      bit r, a, rd, rr;
      logic [63:0] rp;
      check_out("rnd", m_out, m_addr, mq.size() > 0, (mq.size() > 0) ? mq[0].pc : 64'h0);
      r  = ($urandom_range(0, 299) != 0);
      a  = m_out && ($urandom_range(0, 2) != 0);
      rd = ($urandom_range(0, 3) < 2);
      rr = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 3) == 0) rp = 64'hFFFF_FFFF_FFFF_FFF8;
      else                           rp = {$urandom, $urandom} & ~64'h3;
      model_step(r, a, rd, rr, rp);
      step(r, a, rd, rr, rp);
      if (errors > 20) break;
    end

`ifdef FETCH_STATS_EN
    chk("stat_fetched", {32'h0, stat_fetched}, 64'(m_fetched));
    chk("stat_flushes", {48'h0, stat_flushes}, 64'(m_flushes));
    // Six fetches and two redirects from a fresh reset.
    model_step(0,0,0,0,0); step(0,0,0,0,0);
    for (int i = 0; i < 40; i++) begin
      bit rr;
      bit a;
      rr = (i == 5 || i == 11);
      a  = m_out && (m_fetched < 6);
      model_step(1, a, 1, rr, 64'h80);
      step(1, a, 1, rr, 64'h80);
    end
    chk("stat_fetched6", {32'h0, stat_fetched}, 64'd6);
    chk("stat_flushes2", {48'h0, stat_flushes}, 64'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries (power of 2, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 64'h0, fetch address after reset.
REQ-003 SHALL have port clock, input, 1: single clock; all state changes on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port imem_req, output, 1: instruction memory read request.
REQ-006 SHALL have port imem_addr, output, 64: byte address of the request.
REQ-007 SHALL have port imem_ack, input, 1: memory returns imem_data this cycle.
REQ-008 SHALL have port imem_data, input, 32: instruction word.
REQ-009 SHALL have port ir, output, 32: head instruction presented to the control unit.
REQ-010 SHALL have port ir_pc, output, 64: address of ir.
REQ-011 SHALL have port ir_valid, output, 1: ir/ir_pc valid.
REQ-012 SHALL have port ir_ready, input, 1: control unit consumes the head when ir_valid is high.
REQ-013 SHALL have port redirect, input, 1: taken branch; flush the queue and refetch.
REQ-014 SHALL have port redirect_pc, input, 64: new fetch address.

Function
REQ-015 SHALL keep a FIFO of DEPTH {instr, pc} entries; ir/ir_pc SHALL show the head, and ir_valid SHALL equal non-empty.
REQ-016 SHALL use a fetch FSM with states IDLE, REQ and SQUASH.
REQ-017 SHALL go IDLE->REQ when (count + 0) < DEPTH and redirect=0; no new request issues while a request is outstanding.
REQ-018 SHALL, in REQ/SQUASH, hold imem_req=1 and imem_addr stable until imem_ack; imem_req SHALL be 0 in IDLE.
REQ-019 SHALL, on REQ with imem_ack, push {imem_data, imem_addr}, advance fetch_pc by 4, and return to IDLE; an ack in the same cycle a push frees space SHALL be accepted.
REQ-020 SHALL pop the head when ir_valid && ir_ready; a simultaneous push and pop SHALL keep count unchanged.
REQ-021 SHALL, on redirect, empty the queue next cycle (ir_valid=0) and set fetch_pc=redirect_pc; redirect SHALL win over a same-cycle pop and push.
REQ-022 SHALL, on redirect in REQ with imem_ack in the same cycle, discard the data and go IDLE; redirect without ack SHALL go to SQUASH.
REQ-023 SHALL, in SQUASH, keep requesting the stale address, discard data on ack, go IDLE, then fetch from redirect_pc; a further redirect in SQUASH SHALL update fetch_pc only.
REQ-024 SHALL wrap fetch_pc modulo 2^64 and the queue pointers modulo DEPTH.
REQ-025 SHALL give minimum latency from request acceptance to ir_valid of 1 cycle: an ack at edge N gives ir_valid after N.

Reset
REQ-026 SHALL, while reset=0 at a clock edge: set FSM=IDLE, count=0, pointers=0, fetch_pc=RESET_PC, imem_req=0, ir_valid=0, ir=0 and ir_pc=0.
REQ-027 SHALL, on reset mid-request, drop the outstanding transaction with no squash.

Configuration
REQ-028 SHALL, with macro FETCH_STATS_EN defined, add outputs stat_fetched (32-bit, +1 per accepted push) and stat_flushes (16-bit, +1 per redirect), both saturating and cleared by reset.
REQ-029 SHALL, without FETCH_STATS_EN, omit those ports and counters; all other behaviour SHALL be identical.

Verification
REQ-030 Reset then release with imem_ack tied to imem_req -> imem_addr 0,4,8,12; ir=0x910193E4 at ir_pc 0 when memory[0] holds ADDI X4,XZR,100.
REQ-031 ir_ready=0 with DEPTH=4 -> exactly 4 pushes, then imem_req=0; ir_ready=1 for one cycle -> one pop, one new request at address 16.
REQ-032 redirect=1 with redirect_pc=0x40 while REQ waits at 0x8, ack 2 cycles later -> data discarded, next request 0x40, ir_valid=0 until its ack.
REQ-033 redirect, imem_ack and ir_ready all in one cycle -> queue empty, ack data not pushed, count=0.
REQ-034 reset asserted while imem_req=1 -> next cycle imem_req=0, ir_valid=0, fetch restarts at RESET_PC.
REQ-035 FETCH_STATS_EN: 6 accepted fetches and 2 redirects -> stat_fetched=6, stat_flushes=2.
